// File: rtl/nn_pkg.sv
// ============================================================================
// Module : nn_pkg
// Brief  : Shared FSM encoding, default geometry and the requantize helper
//          for nn_result_writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nn_pkg;

   localparam int DEF_ACC_W     = 16;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_N_MACS    = 4;
   localparam int DEF_N         = 4;
   localparam int DEF_BRAM_W    = 64;
   localparam int DEF_MEM_DEPTH = 256;
   localparam int DEF_SHIFT     = 0;

   localparam int EPW    = DEF_BRAM_W / DEF_DATA_W;
   localparam int WORDS  = DEF_N / EPW;
   localparam int GROUPS = DEF_N / DEF_N_MACS;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Arithmetic shift then clamp into a signed data_w range; no ReLU here.
   function automatic logic signed [63:0] sat_shift(
      input logic signed [63:0] acc,
      input int                 shift,
      input int                 data_w
   );
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      y  = acc >>> shift;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (y > hi)
         return hi;
      else if (y < lo)
         return lo;
      return y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nn_requant_lane.sv
// ============================================================================
// Module : nn_requant_lane
// Brief  : Combinational requantizer for one accumulator lane (shift, ReLU
//          when NN_RELU_EN is defined, saturate).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nn_requant_lane
   import nn_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SHIFT  = DEF_SHIFT
) (
   input  logic [ACC_W-1:0]  i_acc,
   output logic [DATA_W-1:0] o_q
);

   logic signed [63:0] w_ext;

`ifdef NN_RELU_EN
   // Clamping the input is equivalent: the shift never changes the sign.
   assign w_ext = i_acc[ACC_W-1] ? 64'sd0 : 64'(i_acc);
`else
   assign w_ext = {{(64-ACC_W){i_acc[ACC_W-1]}}, i_acc};
`endif

   assign o_q = DATA_W'(sat_shift(w_ext, SHIFT, DATA_W));

endmodule

`default_nettype wire

// File: rtl/nn_result_writer.sv
// ============================================================================
// Module : nn_result_writer
// Brief  : Collects MAC lane results, requantizes, packs and writes them to
//          the input BRAM. Optional ReLU via macro NN_RELU_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nn_result_writer
   import nn_pkg::*;
#(
   parameter int ACC_W     = DEF_ACC_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int N_MACS    = DEF_N_MACS,
   parameter int N         = DEF_N,
   parameter int BRAM_W    = DEF_BRAM_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clear,
   input  logic                     i_start,
   input  logic [ADDR_W-1:0]        i_base_addr,
   input  logic [N_MACS*ACC_W-1:0]  i_acc_in,
   input  logic [N_MACS-1:0]        i_valid_in,
   output logic                     o_wr_en,
   output logic                     o_wr_we,
   output logic [ADDR_W-1:0]        o_wr_addr,
   output logic [BRAM_W-1:0]        o_wr_data,
   output logic                     o_busy,
   output logic                     o_layer_done,
   output logic                     o_err
);

   localparam int C_EPW    = BRAM_W / DATA_W;
   localparam int C_WORDS  = N / C_EPW;
   localparam int C_GROUPS = N / N_MACS;
   localparam int C_GC_W   = $clog2(C_GROUPS + 1);
   localparam int C_WC_W   = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
   localparam int C_SI_W   = (N > 1) ? $clog2(N) : 1;

   logic [DATA_W-1:0] w_q [N_MACS];
   logic [N_MACS-1:0] w_seen_nx;
   logic              w_bad_valid;

   state_t            r_state;
   logic [C_GC_W-1:0] r_grp_cnt;
   logic [N_MACS-1:0] r_seen;
   logic [DATA_W-1:0] r_slot [N];
   logic [ADDR_W-1:0] r_addr;
   logic [C_WC_W-1:0] r_word;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   generate
      for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
         nn_requant_lane #(
            .ACC_W  (ACC_W),
            .DATA_W (DATA_W),
            .SHIFT  (SHIFT)
         ) u_lane (
            .i_acc (i_acc_in[gi*ACC_W +: ACC_W]),
            .o_q   (w_q[gi])
         );
      end
   endgenerate

   assign w_seen_nx   = r_seen | i_valid_in;
   // Lanes outside COLLECT are lost; a repeat lane in COLLECT overwrites.
   assign w_bad_valid = (|i_valid_in) &&
                        ((r_state != S_COLLECT) || (|(i_valid_in & r_seen)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_grp_cnt <= '0;
         r_seen    <= '0;
         r_addr    <= '0;
         r_word    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         for (int s = 0; s < N; s++)
            r_slot[s] <= '0;
      end else if (i_clear) begin
         r_state   <= S_IDLE;
         r_grp_cnt <= '0;
         r_seen    <= '0;
         r_word    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         for (int s = 0; s < N; s++)
            r_slot[s] <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_bad_valid)
            r_err <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state   <= S_COLLECT;
                  r_busy    <= 1'b1;
                  r_addr    <= i_base_addr;
                  r_grp_cnt <= '0;
                  r_seen    <= '0;
                  r_word    <= '0;
               end
            end

            S_COLLECT: begin
               for (int i = 0; i < N_MACS; i++) begin
                  if (i_valid_in[i])
                     r_slot[C_SI_W'(int'(r_grp_cnt) * N_MACS + i)] <= w_q[i];
               end
               if (&w_seen_nx) begin
                  r_seen    <= '0;
                  r_grp_cnt <= r_grp_cnt + C_GC_W'(1);
                  if (r_grp_cnt == C_GC_W'(C_GROUPS - 1))
                     r_state <= S_WRITE;
               end else begin
                  r_seen <= w_seen_nx;
               end
            end

            S_WRITE: begin
               r_addr <= (r_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
               r_word <= r_word + C_WC_W'(1);
               if (r_word == C_WC_W'(C_WORDS - 1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_wr_data = '0;
      if (r_state == S_WRITE) begin
         for (int e = 0; e < C_EPW; e++)
            o_wr_data[e*DATA_W +: DATA_W] = r_slot[C_SI_W'(int'(r_word) * C_EPW + e)];
      end
   end

   assign o_wr_en      = (r_state == S_WRITE);
   assign o_wr_we      = (r_state == S_WRITE);
   assign o_wr_addr    = (r_state == S_WRITE) ? r_addr : '0;
   assign o_busy       = r_busy;
   assign o_layer_done = r_done;
   assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nn_result_writer.sv
// ============================================================================
// Module : tb_nn_result_writer
// Brief  : Self-checking bench for nn_result_writer (default and wide/2-word
//          configurations). Honours NN_RELU_EN when defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nn_result_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DUT A: default geometry ----------------
   logic        a_clear = 1'b0, a_start = 1'b0;
   logic [7:0]  a_base  = '0;
   logic [63:0] a_acc   = '0;
   logic [3:0]  a_valid = '0;
   logic        a_wr_en, a_wr_we, a_busy, a_done, a_err;
   logic [7:0]  a_wr_addr;
   logic [63:0] a_wr_data;

   nn_result_writer u_a (
      .clk(clk), .rst(rst), .i_clear(a_clear), .i_start(a_start),
      .i_base_addr(a_base), .i_acc_in(a_acc), .i_valid_in(a_valid),
      .o_wr_en(a_wr_en), .o_wr_we(a_wr_we), .o_wr_addr(a_wr_addr),
      .o_wr_data(a_wr_data), .o_busy(a_busy), .o_layer_done(a_done), .o_err(a_err)
   );

   // ---------------- DUT B: 20-bit acc, SHIFT=2, N=8 ----------------
   logic        b_clear = 1'b0, b_start = 1'b0;
   logic [7:0]  b_base  = '0;
   logic [79:0] b_acc   = '0;
   logic [3:0]  b_valid = '0;
   logic        b_wr_en, b_wr_we, b_busy, b_done, b_err;
   logic [7:0]  b_wr_addr;
   logic [63:0] b_wr_data;

   nn_result_writer #(.ACC_W(20), .N(8), .SHIFT(2)) u_b (
      .clk(clk), .rst(rst), .i_clear(b_clear), .i_start(b_start),
      .i_base_addr(b_base), .i_acc_in(b_acc), .i_valid_in(b_valid),
      .o_wr_en(b_wr_en), .o_wr_we(b_wr_we), .o_wr_addr(b_wr_addr),
      .o_wr_data(b_wr_data), .o_busy(b_busy), .o_layer_done(b_done), .o_err(b_err)
   );

   // ---------------- write monitors ----------------
   logic [7:0]  a_qaddr[$], b_qaddr[$];
   logic [63:0] a_qdata[$], b_qdata[$];
   int a_wcyc, a_dcyc, a_dcnt, a_cap;
   int b_dcnt;

   always @(negedge clk) begin
      if (a_wr_en && a_wr_we) begin
         a_qaddr.push_back(a_wr_addr);
         a_qdata.push_back(a_wr_data);
         a_wcyc = cyc;
      end
      if (a_done) begin
         a_dcnt++;
         a_dcyc = cyc;
      end
      if (b_wr_en && b_wr_we) begin
         b_qaddr.push_back(b_wr_addr);
         b_qdata.push_back(b_wr_data);
      end
      if (b_done) b_dcnt++;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] q_ref(input longint x, input int sh);
      longint y;
      y = x >>> sh;
`ifdef NN_RELU_EN
      if (y < 0) y = 0;
`endif
      if (y > 32767) y = 32767;
      else if (y < -32768) y = -32768;
      return y[15:0];
   endfunction

   function automatic logic [63:0] pack_a(input logic [63:0] acc);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 4; i++)
         w[i*16 +: 16] = q_ref(longint'($signed(acc[i*16 +: 16])), 0);
      return w;
   endfunction

   function automatic logic [63:0] pack_b(input logic [79:0] acc);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 4; i++)
         w[i*16 +: 16] = q_ref(longint'($signed(acc[i*20 +: 20])), 2);
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic a_mon_reset();
      a_qaddr.delete(); a_qdata.delete();
      a_dcnt = 0; a_wcyc = -100; a_dcyc = -100;
   endtask

   task automatic a_clr();
      a_clear = 1'b1; @(posedge clk); #1; a_clear = 1'b0;
   endtask

   task automatic a_begin(input logic [7:0] base);
      a_start = 1'b1; a_base = base; @(posedge clk); #1; a_start = 1'b0;
   endtask

   task automatic a_step(input logic [3:0] v, input logic [63:0] acc);
      if (v != 4'b0) a_cap = cyc;
      a_valid = v; a_acc = acc; @(posedge clk); #1; a_valid = '0;
   endtask

   task automatic a_wait(input string tag);
      int n;
      n = 0;
      while (a_dcnt == 0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) chk({tag, "_timeout"}, 1, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic b_step(input logic [3:0] v, input logic [79:0] acc);
      b_valid = v; b_acc = acc; @(posedge clk); #1; b_valid = '0;
   endtask

   task automatic b_wait(input string tag);
      int n;
      n = 0;
      while (b_dcnt == 0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) chk({tag, "_timeout"}, 1, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic a_layer(input string tag, input logic [7:0] base,
                          input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                          input logic [63:0] acc, input logic [63:0] exp, input logic exp_err);
      a_clr();
      a_mon_reset();
      a_begin(base);
      a_step(v0, acc);
      a_step(v1, acc);
      a_step(v2, acc);
      a_wait(tag);
      chk({tag, "_nwr"},  a_qdata.size(), 1);
      chk({tag, "_addr"}, (a_qaddr.size() > 0) ? a_qaddr[0] : 8'hxx, base);
      chk({tag, "_data"}, (a_qdata.size() > 0) ? a_qdata[0] : 64'hx, exp);
      chk({tag, "_err"},  a_err, exp_err);
      chk({tag, "_ndone"}, a_dcnt, 1);
      chk({tag, "_lat_wr"}, a_wcyc - a_cap, 1);
      chk({tag, "_lat_done"}, a_dcyc - a_wcyc, 1);
   endtask

   typedef struct {
      logic [7:0]  base;
      logic [3:0]  v0, v1, v2;
      logic [63:0] acc;
      logic [63:0] exp;
      logic        exp_err;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [63:0] racc;
      logic [3:0]  m [3];
      logic [79:0] g1, g2;
      logic [63:0] w0;

      tbl[0] = '{8'd1,   4'b1111, 4'b0000, 4'b0000, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 1'b0};
      tbl[1] = '{8'h10,  4'b0001, 4'b0100, 4'b1010, 64'h0008_0007_0006_0005, 64'h0008_0007_0006_0005, 1'b0};
`ifdef NN_RELU_EN
      tbl[2] = '{8'h20,  4'b1111, 4'b0000, 4'b0000, 64'h0000_FFFF_0003_FFFB, 64'h0000_0000_0003_0000, 1'b0};
      tbl[3] = '{8'hFF,  4'b0011, 4'b1100, 4'b0000, 64'h7FFF_8000_0001_0000, 64'h7FFF_0000_0001_0000, 1'b0};
`else
      tbl[2] = '{8'h20,  4'b1111, 4'b0000, 4'b0000, 64'h0000_FFFF_0003_FFFB, 64'h0000_FFFF_0003_FFFB, 1'b0};
      tbl[3] = '{8'hFF,  4'b0011, 4'b1100, 4'b0000, 64'h7FFF_8000_0001_0000, 64'h7FFF_8000_0001_0000, 1'b0};
`endif
      tbl[4] = '{8'h40,  4'b0101, 4'b0101, 4'b1010, 64'h0DEF_0ABC_5678_1234, 64'h0DEF_0ABC_5678_1234, 1'b1};

      // Reset state
      @(negedge clk);
      chk("rst_wr_en", a_wr_en, 0);
      chk("rst_wr_we", a_wr_we, 0);
      chk("rst_addr",  a_wr_addr, 0);
      chk("rst_data",  a_wr_data, 0);
      chk("rst_busy",  a_busy, 0);
      chk("rst_done",  a_done, 0);
      chk("rst_err",   a_err, 0);
      chk("rst_b_busy", b_busy, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 5; t++)
         a_layer($sformatf("vec%0d", t), tbl[t].base, tbl[t].v0, tbl[t].v1, tbl[t].v2,
                 tbl[t].acc, tbl[t].exp, tbl[t].exp_err);

      // Randomized lanes with random arrival cycles
      for (int r = 0; r < 16; r++) begin
         racc = {$urandom, $urandom};
         m[0] = '0; m[1] = '0; m[2] = '0;
         for (int i = 0; i < 4; i++) m[$urandom_range(0, 2)][i] = 1'b1;
         a_layer($sformatf("rnd%0d", r), 8'($urandom), m[0], m[1], m[2], racc, pack_a(racc), 1'b0);
      end

      // Duplicate lane: second value wins, err set
      a_clr(); a_mon_reset(); a_begin(8'h33);
      a_step(4'b0001, 64'h0000_0000_0000_0011);
      a_step(4'b0001, 64'h0000_0000_0000_0022);
      chk("dup_err", a_err, 1);
      a_step(4'b1110, 64'h0004_0003_0002_0000);
      a_wait("dup");
      chk("dup_data", (a_qdata.size() > 0) ? a_qdata[0] : 64'hx, 64'h0004_0003_0002_0022);

      // Busy during COLLECT, start while busy ignored
      a_clr(); a_mon_reset(); a_begin(8'h50);
      chk("collect_busy", a_busy, 1);
      a_step(4'b0001, 64'h1);
      a_start = 1'b1; a_base = 8'h60; @(posedge clk); #1; a_start = 1'b0;
      a_step(4'b1110, 64'h0003_0002_0001_0000);
      a_wait("sbusy");
      chk("sbusy_addr", (a_qaddr.size() > 0) ? a_qaddr[0] : 8'hxx, 8'h50);
      chk("sbusy_ndone", a_dcnt, 1);

      // valid_in in IDLE flags err; clear drops it; clear overrides start
      a_clr();
      a_step(4'b0010, 64'h5);
      chk("idle_valid_err", a_err, 1);
      a_clear = 1'b1; a_start = 1'b1; @(posedge clk); #1; a_clear = 1'b0; a_start = 1'b0;
      chk("clear_err", a_err, 0);
      chk("clear_over_start", a_busy, 0);

      // Reset mid-COLLECT: no write, err dropped
      a_mon_reset(); a_begin(8'h70);
      a_step(4'b0001, 64'h9);
      a_step(4'b0001, 64'h9);
      chk("pre_rst_err", a_err, 1);
      rst = 1'b1; #1;
      chk("midrst_busy", a_busy, 0);
      chk("midrst_err",  a_err, 0);
      @(posedge clk); #1; rst = 1'b0;
      a_step(4'b1110, 64'h9);
      repeat (6) @(posedge clk); #1;
      chk("midrst_nwr",  a_qdata.size(), 0);
      chk("midrst_done", a_dcnt, 0);

      // DUT B: ACC_W=20/SHIFT=2 saturation, two words
      g1 = {20'hFFFF8, 20'h00008, 20'h80000, 20'h7FFFF};
      g2 = {$urandom, $urandom, $urandom};
`ifdef NN_RELU_EN
      w0 = 64'h0000_0002_0000_7FFF;
`else
      w0 = 64'hFFFE_0002_8000_7FFF;
`endif
      b_qaddr.delete(); b_qdata.delete(); b_dcnt = 0;
      b_start = 1'b1; b_base = 8'd7; @(posedge clk); #1; b_start = 1'b0;
      b_step(4'b1111, g1);
      b_step(4'b1111, g2);
      b_wait("sat");
      chk("sat_nwr", b_qdata.size(), 2);
      chk("sat_w0", (b_qdata.size() > 0) ? b_qdata[0] : 64'hx, w0);
      chk("sat_w1", (b_qdata.size() > 1) ? b_qdata[1] : 64'hx, pack_b(g2));
      chk("sat_a1", (b_qaddr.size() > 1) ? b_qaddr[1] : 8'hxx, 8'd8);

      // DUT B: address wrap from 255
      g1 = {20'd4, 20'd3, 20'd2, 20'd1};
      g2 = {20'd8, 20'd7, 20'd6, 20'd5};
      b_qaddr.delete(); b_qdata.delete(); b_dcnt = 0;
      b_start = 1'b1; b_base = 8'd255; @(posedge clk); #1; b_start = 1'b0;
      b_step(4'b1111, g1);
      b_step(4'b1111, g2);
      b_wait("wrap");
      chk("wrap_nwr", b_qdata.size(), 2);
      chk("wrap_a0", (b_qaddr.size() > 0) ? b_qaddr[0] : 8'hxx, 8'd255);
      chk("wrap_a1", (b_qaddr.size() > 1) ? b_qaddr[1] : 8'hxx, 8'd0);
      chk("wrap_w0", (b_qdata.size() > 0) ? b_qdata[0] : 64'hx, pack_b(g1));
      chk("wrap_w1", (b_qdata.size() > 1) ? b_qdata[1] : 64'hx, pack_b(g2));
      chk("wrap_ndone", b_dcnt, 1);
      chk("wrap_err", b_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
